// File: rtl/instruction_fifo_if.sv
// Bundle of the strobe, data and status signals between the sequencer
// front end and the instruction FIFO.
interface instruction_fifo_if #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 4
);
    localparam int CW = $clog2(DEPTH + 1);

    logic             we;
    logic             re;
    logic             del;
    logic [WIDTH-1:0] data_in;
    logic [WIDTH-1:0] data_out;
    logic             empty;
    logic             full;
    logic [CW-1:0]    count;
    logic             err;

    modport master (
        output we, re, del, data_in,
        input  data_out, empty, full, count, err
    );

    modport slave (
        input  we, re, del, data_in,
        output data_out, empty, full, count, err
    );
endinterface

// File: rtl/instruction_fifo.sv
// Circular instruction buffer with edge-qualified save, read and delete-last
// strobes; registered data_out/count/err, empty/full decoded from count.
module instruction_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    instruction_fifo_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] data_out_q, data_out_d;
    logic             err_q, err_d;
    logic             we_q, re_q, del_q;
    logic             we_p_s, re_p_s, del_p_s;
    logic             push_s, pop_s, drop_s;
    logic             empty_s, full_s;

    // Strobe qualification and arbitration between concurrent requests
    always_comb begin
        empty_s = (count_q == {CW{1'b0}});
        full_s  = (count_q == CW'(DEPTH));
        we_p_s  = bus.we  & ~we_q;
        re_p_s  = bus.re  & ~re_q;
        del_p_s = bus.del & ~del_q;
        pop_s   = re_p_s & ~empty_s;
        // A pop of the only entry wins over deleting it.
        drop_s  = del_p_s & ~empty_s & ~(re_p_s & (count_q == CW'(1'b1)));
        // Delete always wins over save; a concurrent pop frees the slot when full.
        push_s  = we_p_s & ~del_p_s & (~full_s | pop_s);
        err_d   = (we_p_s & ~push_s) | (re_p_s & ~pop_s) | (del_p_s & ~drop_s);
    end

    // Next-state for pointers, occupancy and the output register
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        data_out_d = data_out_q;
        count_d    = count_q + CW'(push_s) - CW'(pop_s) - CW'(drop_s);
        if (push_s) begin
            wr_ptr_d = wr_ptr_q + AW'(1'b1);
        end else if (drop_s) begin
            wr_ptr_d = wr_ptr_q - AW'(1'b1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d   = rd_ptr_q + AW'(1'b1);
            data_out_d = mem_q[rd_ptr_q];
        end else begin
            rd_ptr_d   = rd_ptr_q;
            data_out_d = data_out_q;
        end
    end

    // Control and status registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q   <= {AW{1'b0}};
            rd_ptr_q   <= {AW{1'b0}};
            count_q    <= {CW{1'b0}};
            data_out_q <= {WIDTH{1'b0}};
            err_q      <= 1'b0;
            we_q       <= 1'b0;
            re_q       <= 1'b0;
            del_q      <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            data_out_q <= data_out_d;
            err_q      <= err_d;
            we_q       <= bus.we;
            re_q       <= bus.re;
            del_q      <= bus.del;
        end
    end

    // Instruction storage; contents are never reset
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= bus.data_in;
        end
    end

    assign bus.data_out = data_out_q;
    assign bus.count    = count_q;
    assign bus.err      = err_q;
    assign bus.empty    = empty_s;
    assign bus.full     = full_s;
endmodule

// File: tb/tb_instruction_fifo.sv
// Directed scoreboard bench for instruction_fifo: each driven cycle queues its
// hand-computed expected outputs, a monitor checks them after the clock edge.
module tb_instruction_fifo;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    instruction_fifo_if #(.DEPTH(8), .WIDTH(4)) bus ();
    instruction_fifo #(.DEPTH(8), .WIDTH(4)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic [3:0] dout;
        logic [3:0] cnt;
        logic       err;
        int         id;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks  = 0;
    int   errors  = 0;
    int   step_id = 0;

    task automatic chk(input string name, input int id, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s (step %0d): got 0x%0h, required 0x%0h", name, id, act, req);
        end
    endtask

    task automatic step(input logic w, input logic r, input logic d, input logic [3:0] din,
                        input logic [3:0] e_dout, input logic [3:0] e_cnt, input logic e_err);
        @(negedge clk);
        rst         = 1'b1;
        bus.we      = w;
        bus.re      = r;
        bus.del     = d;
        bus.data_in = din;
        step_id++;
        exp_q.push_back('{e_dout, e_cnt, e_err, step_id});
    endtask

    task automatic idle(input int n, input logic [3:0] e_dout, input logic [3:0] e_cnt);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 4'h0, e_dout, e_cnt, 1'b0);
    endtask

    task automatic pushv(input logic [3:0] din, input logic [3:0] e_dout, input logic [3:0] e_cnt);
        step(1'b1, 1'b0, 1'b0, din, e_dout, e_cnt, 1'b0);
        idle(1, e_dout, e_cnt);
    endtask

    task automatic popv(input logic [3:0] e_dout, input logic [3:0] e_cnt);
        step(1'b0, 1'b1, 1'b0, 4'h0, e_dout, e_cnt, 1'b0);
        idle(1, e_dout, e_cnt);
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_count"}, step_id, 32'(bus.count), 32'd0);
        chk({tag, "_data_out"}, step_id, 32'(bus.data_out), 32'd0);
        chk({tag, "_err"}, step_id, 32'(bus.err), 32'd0);
        chk({tag, "_empty"}, step_id, 32'(bus.empty), 32'd1);
        chk({tag, "_full"}, step_id, 32'(bus.full), 32'd0);
    endtask

    // Monitor: compare the queued expectation just after each rising edge
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            chk("data_out", mon_e.id, 32'(bus.data_out), 32'(mon_e.dout));
            chk("count", mon_e.id, 32'(bus.count), 32'(mon_e.cnt));
            chk("err", mon_e.id, 32'(bus.err), 32'(mon_e.err));
            chk("empty", mon_e.id, 32'(bus.empty), 32'(mon_e.cnt == 4'd0));
            chk("full", mon_e.id, 32'(bus.full), 32'(mon_e.cnt == 4'd8));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        rst         = 1'b0;
        bus.we      = 1'b0;
        bus.re      = 1'b0;
        bus.del     = 1'b0;
        bus.data_in = 4'h0;
        #1;
        check_reset_state("por");

        // Basic ordering
        pushv(4'h3, 4'h0, 4'd1);
        pushv(4'h6, 4'h0, 4'd2);
        pushv(4'h9, 4'h0, 4'd3);
        popv(4'h3, 4'd2);
        popv(4'h6, 4'd1);
        popv(4'h9, 4'd0);

        // Held levels perform exactly one operation
        for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 1'b0, 4'hA, 4'h9, 4'd1, 1'b0);
        idle(1, 4'h9, 4'd1);
        for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 1'b0, 4'h0, 4'hA, 4'd0, 1'b0);
        idle(1, 4'hA, 4'd0);

        // Fill, overflow rejection, drain, underflow rejection
        for (int k = 1; k <= 8; k++) pushv(4'(k), 4'hA, 4'(k));
        step(1'b1, 1'b0, 1'b0, 4'hF, 4'hA, 4'd8, 1'b1);
        idle(1, 4'hA, 4'd8);
        for (int k = 1; k <= 8; k++) popv(4'(k), 4'(8 - k));
        step(1'b0, 1'b1, 1'b0, 4'h0, 4'h8, 4'd0, 1'b1);
        idle(1, 4'h8, 4'd0);

        // Delete-last
        pushv(4'h1, 4'h8, 4'd1);
        pushv(4'h2, 4'h8, 4'd2);
        pushv(4'h3, 4'h8, 4'd3);
        step(1'b0, 1'b0, 1'b1, 4'h0, 4'h8, 4'd2, 1'b0);
        idle(1, 4'h8, 4'd2);
        popv(4'h1, 4'd1);
        popv(4'h2, 4'd0);
        step(1'b0, 1'b1, 1'b0, 4'h0, 4'h2, 4'd0, 1'b1);
        idle(1, 4'h2, 4'd0);

        // del+re with a single entry: pop wins
        pushv(4'h5, 4'h2, 4'd1);
        step(1'b0, 1'b1, 1'b1, 4'h0, 4'h5, 4'd0, 1'b1);
        idle(1, 4'h5, 4'd0);

        // we+re with pointers wrapped keeps count and order
        for (int k = 1; k <= 5; k++) pushv(4'(k), 4'h5, 4'(k));
        step(1'b1, 1'b1, 1'b0, 4'h6, 4'h1, 4'd5, 1'b0);
        idle(1, 4'h1, 4'd5);
        for (int k = 2; k <= 6; k++) popv(4'(k), 4'(6 - k));

        // we+re when empty: push only, err, no fall-through
        step(1'b1, 1'b1, 1'b0, 4'h7, 4'h6, 4'd1, 1'b1);
        idle(1, 4'h6, 4'd1);
        // del+we: delete only, push dropped with err
        step(1'b1, 1'b0, 1'b1, 4'h9, 4'h6, 4'd0, 1'b1);
        idle(1, 4'h6, 4'd0);
        // del+re with two entries: both commit
        pushv(4'hB, 4'h6, 4'd1);
        pushv(4'hC, 4'h6, 4'd2);
        step(1'b0, 1'b1, 1'b1, 4'h0, 4'hB, 4'd0, 1'b0);
        idle(1, 4'hB, 4'd0);

        // Mid-operation reset with re held through release
        for (int k = 1; k <= 4; k++) pushv(4'(k), 4'hB, 4'(k));
        @(negedge clk);
        rst    = 1'b0;
        bus.re = 1'b1;
        #1;
        check_reset_state("midrst");
        step(1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 4'd0, 1'b1);
        step(1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 4'd0, 1'b0);
        idle(2, 4'h0, 4'd0);

        repeat (3) @(posedge clk);
        #2;
        chk("drain", step_id, 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
